mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the CPU's single memory bus between the control path's instruction fetch and the datapath's load/store requests. Each request is granted in turn and run as one Avalon-style transfer with waitrequest back-pressure. Returned words are held in registers, and one `stall` signal freezes the CPU until the pending access is acknowledged. The block sits between the CPU core (control path and datapath) and the external memory interface.

## Interface
- TIMEOUT, 255: maximum bus cycles with waitrequest high before a transfer is aborted; 0 disables the timeout; legal range 0..65535.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- fetch_req  in  1  instruction fetch request; held high until fetch_ack.
- fetch_addr  in  32  fetch word address; stable while fetch_req is high.
- data_read  in  1  load request; held until data_ack.
- data_write  in  1  store request; held until data_ack.
- data_addr  in  32  load/store address.
- data_writedata  in  32  store data.
- data_byteenable  in  4  store/load byte lanes.
- fetch_ack  out  1  one-cycle pulse; instr_readdata valid.
- instr_readdata  out  32  last fetched word; held until the next fetch completes.
- data_ack  out  1  one-cycle pulse; data access complete.
- data_readdata  out  32  last loaded word; held until the next load completes.
- bus_error  out  1  one-cycle pulse coincident with an ack when the transfer timed out.
- stall  out  1  combinational: (fetch_req | data_read | data_write) & ~(fetch_ack | data_ack).
- address  out  32  bus address.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- writedata  out  32  bus write data.
- byteenable  out  4  bus byte lanes; 4'b1111 for fetches.
- waitrequest  in  1  slave back-pressure.
- readdata  in  32  slave read data; valid in the cycle waitrequest is low during a read.

## Operation

**States:** IDLE, BUS, ACK.

**IDLE**
- Samples the request inputs each cycle.
- Data requests have fixed priority over fetch.
- data_write and data_read both high is treated as a write.
- On a grant, latches the request: source (FETCH/DATA), direction, address, writedata, byteenable.
- Clears the wait counter and moves to BUS.
- With no request, stays in IDLE.

**BUS**
- Drives read or write, address, writedata and byteenable from the latched registers. All bus outputs are registered.
- If waitrequest is low at a rising edge, the transfer completes:
  - A read captures readdata into instr_readdata (FETCH) or data_readdata (DATA).
  - The block moves to ACK.
- If waitrequest is high, the wait counter increments.
- If TIMEOUT≠0 and the counter reaches TIMEOUT while waitrequest is high:
  - Abort the transfer and set the error flag.
  - A read loads 32'h0000_0000 into the destination register.
  - Move to ACK.

**ACK**
- Read/write are low.
- Exactly one of fetch_ack or data_ack is high, matching the latched source. bus_error is high if the error flag is set.
- New requests are ignored this cycle. The block returns to IDLE on the next edge.
- The requester must deassert its request, or present a new one, before that edge.

**Reset values**
- State is IDLE; the wait counter and error flag are cleared.
- read, write, fetch_ack, data_ack and bus_error are 0.
- address, writedata, instr_readdata and data_readdata are 0; byteenable is 4'b0000.

**Reset mid-transfer**
- read/write drop at the next edge. No ack or error is issued.
- The held readdata registers are cleared.

Request inputs are not re-sampled in BUS. Changes to fetch_addr or data_* during BUS have no effect.

## Timing
- Zero-wait read:
  - Request high in cycle 0 (IDLE).
  - read high in cycle 1, waitrequest low.
  - Ack plus valid data in cycle 2.
  - IDLE in cycle 3.
  - Minimum 3 cycles per access; the next grant is in cycle 3.
- Each waitrequest-high cycle in BUS adds one cycle.
- Timeout: with TIMEOUT=N, the ack/error cycle comes N+2 cycles after the request cycle.
- stall is high from the request cycle through the cycle before the ack, and low in the ack cycle.
- Back-to-back: data wins in cycle 0. A fetch pending in parallel is granted in the IDLE cycle after the data ack, provided data_read and data_write are low by then.

## Test plan
- **Single fetch:** fetch_req=1 with fetch_addr=0xBFC00000; slave returns 0x8C410004 with 0 waits. Expect read=1, byteenable=4'hF in cycle 1; fetch_ack and instr_readdata=0x8C410004 in cycle 2; stall low in cycle 2.
- **Store with 3 wait cycles:** data_write=1, data_addr=0x1000, data_writedata=0xDEADBEEF, data_byteenable=4'b0011. Expect write held for 4 cycles with stable address/data/byteenable; data_ack in cycle 5; readdata registers unchanged.
- **Simultaneous fetch_req and data_read:** expect the load granted first and data_ack in cycle 2; fetch read strobe in cycle 4 and fetch_ack in cycle 5.
- **Timeout:** TIMEOUT=4, fetch with waitrequest stuck high. Expect fetch_ack and bus_error together in cycle 6, instr_readdata=0, read low from cycle 6.
- **Reset mid-transfer:** assert reset in the second BUS cycle of a waited load. Expect read=0, data_readdata=0 and no data_ack after that edge. A fresh load after reset completes normally.
- **Hold after completion:** after a fetch of 0x12345678, run a store. Expect instr_readdata to remain 0x12345678 throughout.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates CPU fetch and load/store onto one Avalon-style bus; 3 cycles per access plus one per waitrequest cycle.
// Data beats fetch; waitrequest stretches BUS until TIMEOUT aborts it; stall holds the CPU until the ack pulse.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic        fetch_ack,
  output logic [31:0] instr_readdata,
  output logic        data_ack,
  output logic [31:0] data_readdata,
  output logic        bus_error,
  output logic        stall,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_BUS  = 2'd1;
  localparam logic [1:0]  S_ACK  = 2'd2;
  localparam logic [15:0] TMO    = 16'(TIMEOUT);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic        src_data;
  logic        is_write;
  logic        timeout_hit;

  // Abort on the cycle the counter already equals TMO with the slave still waiting.
  assign timeout_hit = (TMO != 16'd0) && waitrequest && (wait_cnt == TMO);

  assign stall = (fetch_req | data_read | data_write) & ~(fetch_ack | data_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      wait_cnt       <= 16'd0;
      src_data       <= 1'b0;
      is_write       <= 1'b0;
      read           <= 1'b0;
      write          <= 1'b0;
      address        <= 32'd0;
      writedata      <= 32'd0;
      byteenable     <= 4'b0000;
      fetch_ack      <= 1'b0;
      data_ack       <= 1'b0;
      bus_error      <= 1'b0;
      instr_readdata <= 32'd0;
      data_readdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
          bus_error <= 1'b0;
          if (data_read || data_write) begin
            src_data   <= 1'b1;
            is_write   <= data_write;
            address    <= data_addr;
            writedata  <= data_writedata;
            byteenable <= data_byteenable;
            read       <= ~data_write;
            write      <= data_write;
            wait_cnt   <= 16'd0;
            state      <= S_BUS;
          end else if (fetch_req) begin
            src_data   <= 1'b0;
            is_write   <= 1'b0;
            address    <= fetch_addr;
            writedata  <= 32'd0;
            byteenable <= 4'b1111;
            read       <= 1'b1;
            write      <= 1'b0;
            wait_cnt   <= 16'd0;
            state      <= S_BUS;
          end
        end
        S_BUS: begin
          if (!waitrequest || timeout_hit) begin
            read      <= 1'b0;
            write     <= 1'b0;
            fetch_ack <= ~src_data;
            data_ack  <= src_data;
            bus_error <= waitrequest;
            if (!is_write) begin
              if (src_data) data_readdata  <= waitrequest ? 32'd0 : readdata;
              else          instr_readdata <= waitrequest ? 32'd0 : readdata;
            end
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_ACK: begin
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
          bus_error <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: each access is modelled as a timeline (grant, N bus cycles, ack)
// derived from the wait count the bench's slave will apply, and every output is compared each cycle.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        data_read, data_write;
  logic [31:0] data_addr, data_writedata;
  logic [3:0]  data_byteenable;
  logic        fetch_ack, data_ack, bus_error, stall;
  logic [31:0] instr_readdata, data_readdata;
  logic [31:0] address, writedata;
  logic        read, write;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .fetch_ack(fetch_ack), .instr_readdata(instr_readdata),
    .data_ack(data_ack), .data_readdata(data_readdata),
    .bus_error(bus_error), .stall(stall),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic        e_read, e_write, e_fack, e_dack, e_err;
  logic [31:0] e_addr, e_wd, e_instr, e_drd;
  logic [3:0]  e_be;
  logic [31:0] m_addr, m_wd, m_instr, m_drd;
  logic [3:0]  m_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("read",       32'(read),       32'(e_read));
      chk("write",      32'(write),      32'(e_write));
      chk("fetch_ack",  32'(fetch_ack),  32'(e_fack));
      chk("data_ack",   32'(data_ack),   32'(e_dack));
      chk("bus_error",  32'(bus_error),  32'(e_err));
      chk("address",    address,         e_addr);
      chk("writedata",  writedata,       e_wd);
      chk("byteenable", 32'(byteenable), 32'(e_be));
      chk("instr_rd",   instr_readdata,  e_instr);
      chk("data_rd",    data_readdata,   e_drd);
      chk("stall",      32'(stall),
          32'((fetch_req | data_read | data_write) & ~(e_fack | e_dack)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_exp();
    e_read = 1'b0; e_write = 1'b0; e_fack = 1'b0; e_dack = 1'b0; e_err = 1'b0;
    e_addr = m_addr; e_wd = m_wd; e_be = m_be; e_instr = m_instr; e_drd = m_drd;
  endtask

  task automatic model_reset();
    m_addr = 32'd0; m_wd = 32'd0; m_be = 4'd0; m_instr = 32'd0; m_drd = 32'd0;
  endtask

  task automatic scramble();
    fetch_addr      = $urandom;
    data_addr       = $urandom;
    data_writedata  = $urandom;
    data_byteenable = 4'($urandom);
  endtask

  task automatic req_data(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    data_read = rd; data_write = wr; data_addr = a; data_writedata = wd; data_byteenable = be;
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the ACK cycle.
  // The slave holds waitrequest high for the first w bus cycles, then returns rdv.
  task automatic run_txn(input int w, input logic [31:0] rdv, output int ack_at, output int n_strobe);
    logic g_data, g_wr, err;
    logic [31:0] a, d;
    logic [3:0] be;
    int nb;
    g_data = data_read | data_write;
    g_wr   = data_write;
    a  = g_data ? data_addr : fetch_addr;
    d  = g_data ? data_writedata : 32'h0;
    be = g_data ? data_byteenable : 4'hF;
    err = (TMO != 0) && (w > TMO);
    nb  = err ? TMO + 1 : w + 1;
    ack_at = -1;
    n_strobe = 0;
    hold_exp();
    chk_en = 1'b1;
    for (int k = 1; k <= nb + 1; k++) begin
      step();
      readdata    = $urandom;
      waitrequest = 1'($urandom);
      if (k <= nb) begin
        waitrequest = (k <= w);
        if (k == nb && !err) readdata = rdv;
        scramble();
        e_read = !g_wr; e_write = g_wr; e_addr = a; e_wd = d; e_be = be;
      end else begin
        if (g_data) begin data_read = 1'b0; data_write = 1'b0; end
        else fetch_req = 1'b0;
        if (!g_wr) begin
          if (g_data) m_drd = err ? 32'h0 : rdv;
          else        m_instr = err ? 32'h0 : rdv;
        end
        m_addr = a; m_wd = d; m_be = be;
        hold_exp();
        e_fack = !g_data; e_dack = g_data; e_err = err;
      end
      #2;
      if (read | write) n_strobe++;
      if ((fetch_ack | data_ack) && ack_at < 0) ack_at = k;
    end
  endtask

  initial begin
    int at, ns;
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = 32'h0;
    req_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitrequest = 1'b0; readdata = 32'h0;
    model_reset();
    hold_exp();
    step();
    step();
    chk_en = 1'b1;
    chk("reset_strobes", 32'({read, write, fetch_ack, data_ack, bus_error}), 32'h0);
    chk("reset_be", 32'(byteenable), 32'h0);
    reset = 1'b0;

    // Single zero-wait fetch
    step(); hold_exp();
    fetch_req = 1'b1; fetch_addr = 32'hBFC0_0000;
    run_txn(0, 32'h8C41_0004, at, ns);
    chk("fetch_ack_cycle", at, 2);
    chk("fetch_instr", instr_readdata, 32'h8C41_0004);
    chk("fetch_strobes", ns, 1);

    // Store with three wait cycles
    step(); hold_exp();
    req_data(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
    run_txn(3, 32'h5555_AAAA, at, ns);
    chk("store_ack_cycle", at, 5);
    chk("store_strobes", ns, 4);
    chk("store_keeps_drd", data_readdata, 32'h0);
    chk("store_keeps_instr", instr_readdata, 32'h8C41_0004);

    // Simultaneous load and fetch: load first, fetch granted right after
    step(); hold_exp();
    fetch_req = 1'b1; fetch_addr = 32'h0040_0000;
    req_data(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
    run_txn(0, 32'hCAFE_F00D, at, ns);
    chk("both_data_ack_cycle", at, 2);
    chk("both_data_rd", data_readdata, 32'hCAFE_F00D);
    step(); hold_exp();
    run_txn(0, 32'h0BAD_C0DE, at, ns);
    chk("both_fetch_ack_cycle", at + 3, 5);
    chk("both_fetch_instr", instr_readdata, 32'h0BAD_C0DE);

    // Timeout with waitrequest stuck high
    step(); hold_exp();
    fetch_req = 1'b1; fetch_addr = 32'h0000_0100;
    run_txn(20, 32'hFFFF_FFFF, at, ns);
    chk("tmo_ack_cycle", at, 6);
    chk("tmo_bus_error", 32'(bus_error), 32'h1);
    chk("tmo_instr", instr_readdata, 32'h0);
    chk("tmo_strobes", ns, 5);

    // Fetched word held across a store
    step(); hold_exp();
    fetch_req = 1'b1; fetch_addr = 32'h0000_0200;
    run_txn(1, 32'h1234_5678, at, ns);
    step(); hold_exp();
    req_data(1'b0, 1'b1, 32'h0000_3000, 32'h0F0F_0F0F, 4'b1100);
    run_txn(2, 32'h9999_9999, at, ns);
    chk("hold_instr", instr_readdata, 32'h1234_5678);

    // Reset in the second bus cycle of a waited load
    step(); hold_exp();
    req_data(1'b1, 1'b0, 32'h0000_3100, 32'h0, 4'hF);
    run_txn(0, 32'hA5A5_0001, at, ns);
    step(); hold_exp();
    req_data(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hC);
    step();
    waitrequest = 1'b1; readdata = $urandom;
    e_read = 1'b1; e_addr = 32'h0000_4000; e_wd = 32'h0; e_be = 4'hC;
    step();
    waitrequest = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; data_read = 1'b0;
    model_reset(); hold_exp();
    #2;
    chk("rst_mid_read", 32'(read), 32'h0);
    chk("rst_mid_drd", data_readdata, 32'h0);
    chk("rst_mid_dack", 32'(data_ack), 32'h0);
    step(); hold_exp();
    req_data(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
    run_txn(2, 32'h600D_F00D, at, ns);
    chk("post_rst_ack_cycle", at, 4);
    chk("post_rst_drd", data_readdata, 32'h600D_F00D);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      step(); hold_exp();
      waitrequest = 1'($urandom); readdata = $urandom;
      if (!fetch_req) begin
        case ($urandom_range(0, 6))
          1: begin fetch_req = 1'b1; fetch_addr = $urandom; end
          2: req_data(1'b1, 1'b0, $urandom, $urandom, 4'($urandom));
          3: req_data(1'b0, 1'b1, $urandom, $urandom, 4'($urandom));
          4: req_data(1'b1, 1'b1, $urandom, $urandom, 4'($urandom));
          5: begin
            fetch_req = 1'b1; fetch_addr = $urandom;
            req_data(1'b1, 1'b0, $urandom, $urandom, 4'($urandom));
          end
          6: begin
            fetch_req = 1'b1; fetch_addr = $urandom;
            req_data(1'b0, 1'b1, $urandom, $urandom, 4'($urandom));
          end
          default: ;
        endcase
      end else if ($urandom_range(0, 1) == 1) begin
        req_data(1'($urandom), 1'b1, $urandom, $urandom, 4'($urandom));
      end
      if (fetch_req | data_read | data_write)
        run_txn($urandom_range(0, 7), $urandom, at, ns);
    end

    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
